pmem_burst_adaptor: RTL and testbench
=====================================

PMEM_BURST_ADAPTOR -- requirements
Module: pmem_burst_adaptor

Interface
REQ-001 SHALL have parameter ALIGN_ADDR, default 1; when 1, address_o[4:0] is forced to 0 (32-byte line alignment); when 0, the address passes unmodified.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port line_read_i, input, 1 bit: line read request from the L2 (pmem_read), held high until line_resp_o.
REQ-005 SHALL have port line_write_i, input, 1 bit: line write request from the L2 (pmem_write), held high until line_resp_o.
REQ-006 SHALL have port line_address_i, input, 32 bits: line address (pmem_address).
REQ-007 SHALL have port line_wdata_i, input, 256 bits: line to write (pmem_wdata).
REQ-008 SHALL have port line_rdata_o, output, 256 bits: assembled read line (pmem_rdata).
REQ-009 SHALL have port line_resp_o, output, 1 bit: one-cycle completion pulse (pmem_resp).
REQ-010 SHALL have port burst_rdata_i, input, 64 bits: memory read beat.
REQ-011 SHALL have port burst_wdata_o, output, 64 bits: memory write beat.
REQ-012 SHALL have port address_o, output, 32 bits: memory burst address.
REQ-013 SHALL have port read_o, output, 1 bit: memory burst read request.
REQ-014 SHALL have port write_o, output, 1 bit: memory burst write request.
REQ-015 SHALL have port resp_i, input, 1 bit: memory beat-valid/beat-accept strobe.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, RD_BURST, WR_BURST, DONE, plus a 2-bit beat counter.
REQ-017 In IDLE, line_write_i high SHALL capture line_wdata_i and the address and go to WR_BURST; write wins if both requests are high.
REQ-018 In IDLE, line_read_i high with line_write_i low SHALL capture the address and go to RD_BURST.
REQ-019 read_o SHALL be high exactly while in RD_BURST; write_o SHALL be high exactly while in WR_BURST; both are decoded from state, so a request accepted in cycle N drives read_o/write_o from cycle N+1.
REQ-020 address_o SHALL present the captured address, held constant from acceptance until the next acceptance.
REQ-021 Beats SHALL be counted only in cycles where resp_i is high while in a burst state; gaps (resp_i low) are legal and stall the counter.
REQ-022 Read beat k (k=0..3) SHALL be written to line_rdata_o[64k+63:64k] on the clock edge where it is accepted.
REQ-023 In WR_BURST, burst_wdata_o SHALL combinationally equal captured line bits [64k+63:64k], where k is the current beat count; the value is 0 outside WR_BURST.
REQ-024 On acceptance of beat 3, the FSM SHALL move to DONE and the counter SHALL wrap to 0.
REQ-025 line_resp_o SHALL be high only in DONE, for exactly one cycle; DONE SHALL always return to IDLE; a request still high in that IDLE cycle is treated as a new request.
REQ-026 line_rdata_o SHALL hold its last assembled line until the next read overwrites it; writes SHALL NOT alter it.
REQ-027 resp_i in IDLE or DONE SHALL be ignored.
REQ-028 Request inputs SHALL be ignored while a burst is in progress; the captured address and data SHALL NOT change mid-burst.
REQ-029 Latency SHALL be: resp_i beats in cycles k..k+3 (contiguous) produce line_resp_o in cycle k+4.

Reset
REQ-030 With rst high at a clock edge, the FSM SHALL go to IDLE, the counter to 0, line_rdata_o and the captured address/data to 0; read_o, write_o and line_resp_o SHALL be 0 in the following cycle.
REQ-031 Reset mid-burst SHALL abort the burst with no line_resp_o; the bench SHALL treat further resp_i as ignored.

Verification
REQ-032 Read: address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 contiguous -> address_o=0x0000_1220, line_rdata_o=0x44..44_33..33_22..22_11..11, one line_resp_o pulse.
REQ-033 Write: line_wdata_i=0xDDDD..._CCCC..._BBBB..._AAAA... -> burst_wdata_o = A, B, C, D on successive resp_i beats; write_o drops after beat 3; line_resp_o on the next cycle.
REQ-034 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> four beats assembled in order; line_resp_o exactly one cycle after the final beat.
REQ-035 Write-then-read back-to-back (L2 writeback then allocate) -> second burst starts the cycle after DONE; read_o never overlaps write_o.
REQ-036 rst asserted after beat 2 of a read -> IDLE, outputs 0, no line_resp_o; a fresh read then completes correctly.
REQ-037 line_read_i and line_write_i both high -> write burst performed; stray resp_i in IDLE has no effect on the counter.

Source files
------------

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: converts 256-bit L2 line requests into four 64-bit
// memory beats (read or write). Beats advance only on resp_i, so the memory
// side may insert any number of idle cycles between beats.
module pmem_burst_adaptor #(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read_i,
  input  logic         line_write_i,
  input  logic [31:0]  line_address_i,
  input  logic [255:0] line_wdata_i,
  output logic [255:0] line_rdata_o,
  output logic         line_resp_o,
  input  logic [63:0]  burst_rdata_i,
  output logic [63:0]  burst_wdata_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rdata_q, rdata_d;

  // Select 64-bit beat k of a 256-bit line (beat 0 is the least significant).
  function automatic logic [63:0] line_beat(input logic [255:0] line, input logic [1:0] k);
    logic [63:0] b;
    case (k)
      2'd0:    b = line[63:0];
      2'd1:    b = line[127:64];
      2'd2:    b = line[191:128];
      2'd3:    b = line[255:192];
      default: b = 64'd0;
    endcase
    return b;
  endfunction

  // Replace beat k of a line with a new 64-bit value.
  function automatic logic [255:0] line_insert(input logic [255:0] line, input logic [1:0] k,
                                               input logic [63:0] b);
    logic [255:0] l;
    l = line;
    case (k)
      2'd0:    l[63:0]    = b;
      2'd1:    l[127:64]  = b;
      2'd2:    l[191:128] = b;
      2'd3:    l[255:192] = b;
      default: l = line;
    endcase
    return l;
  endfunction

  // Next-state logic: request capture in IDLE, beat counting in bursts.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Write has priority so a dirty-line writeback is never lost.
        if (line_write_i) begin
          addr_d  = line_address_i;
          wdata_d = line_wdata_i;
          state_d = WR_BURST;
        end else if (line_read_i) begin
          addr_d  = line_address_i;
          state_d = RD_BURST;
        end else begin
          state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          rdata_d = line_insert(rdata_q, beat_q, burst_rdata_i);
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // State, counter and line registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    read_o      = (state_q == RD_BURST);
    write_o     = (state_q == WR_BURST);
    line_resp_o = (state_q == DONE);
    if (state_q == WR_BURST) begin
      burst_wdata_o = line_beat(wdata_q, beat_q);
    end else begin
      burst_wdata_o = 64'd0;
    end
    if (ALIGN_ADDR) begin
      address_o = {addr_q[31:5], 5'd0};
    end else begin
      address_o = addr_q;
    end
  end

  assign line_rdata_o = rdata_q;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Self-checking bench for pmem_burst_adaptor: directed vector table,
// hand-written reset/stray-strobe sequences and randomized transactions
// checked against a transaction-level model of the line interface.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_address_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [63:0]  burst_rdata_i;
  logic [63:0]  burst_wdata_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_chk  = 0;
  int n_fail = 0;
  logic [255:0] last_line;

  pmem_burst_adaptor dut (
    .clk            (clk),
    .rst            (rst),
    .line_read_i    (line_read_i),
    .line_write_i   (line_write_i),
    .line_address_i (line_address_i),
    .line_wdata_i   (line_wdata_i),
    .line_rdata_o   (line_rdata_o),
    .line_resp_o    (line_resp_o),
    .burst_rdata_i  (burst_rdata_i),
    .burst_wdata_o  (burst_wdata_o),
    .address_o      (address_o),
    .read_o         (read_o),
    .write_o        (write_o),
    .resp_i         (resp_i)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] beats;
    logic [15:0]  pat;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One complete line transaction, called just after a rising edge in IDLE.
  // pat gives resp_i per burst cycle (LSB first); after 16 cycles resp_i is 1.
  task automatic run_txn(input string nm, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [255:0] wd,
                         input logic [255:0] beats, input logic [15:0] pat,
                         input bit perturb, input logic [31:0] exp_addr,
                         input logic [255:0] exp_line);
    int  b;
    int  cyc;
    bit  go;
    line_read_i    = rd;
    line_write_i   = wr;
    line_address_i = addr;
    line_wdata_i   = wd;
    resp_i         = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_read"},  {255'd0, read_o},      256'd0);
    chk({nm, "_idle_write"}, {255'd0, write_o},     256'd0);
    chk({nm, "_idle_resp"},  {255'd0, line_resp_o}, 256'd0);
    @(posedge clk); #1;
    b   = 0;
    cyc = 0;
    while (b < 4 && cyc < 40) begin
      go            = (cyc >= 16) ? 1'b1 : pat[cyc];
      resp_i        = go;
      burst_rdata_i = go ? beats[64*b +: 64] : {$urandom, $urandom};
      if (perturb) begin
        line_address_i = $urandom;
        line_wdata_i   = rnd256();
      end
      @(negedge clk);
      chk({nm, "_read_o"},  {255'd0, read_o},      {255'd0, (rd && !wr)});
      chk({nm, "_write_o"}, {255'd0, write_o},     {255'd0, wr});
      chk({nm, "_addr"},    {224'd0, address_o},   {224'd0, exp_addr});
      chk({nm, "_noresp"},  {255'd0, line_resp_o}, 256'd0);
      if (wr) chk({nm, "_wbeat"}, {192'd0, burst_wdata_o}, {192'd0, wd[64*b +: 64]});
      else    chk({nm, "_wzero"}, {192'd0, burst_wdata_o}, 256'd0);
      @(posedge clk); #1;
      if (go) b++;
      cyc++;
    end
    if (b < 4) chk({nm, "_timeout"}, 256'd0, 256'd1);
    resp_i = 1'b0;
    @(negedge clk);
    chk({nm, "_done_resp"},  {255'd0, line_resp_o}, 256'd1);
    chk({nm, "_done_read"},  {255'd0, read_o},      256'd0);
    chk({nm, "_done_write"}, {255'd0, write_o},     256'd0);
    @(posedge clk); #1;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    chk({nm, "_line"}, line_rdata_o, exp_line);
    last_line = exp_line;
  endtask

  initial begin
    logic [255:0] l032, l034, l035r;
    l032  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l034  = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    l035r = {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB,
             64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999};
    vecs[0] = '{"rd032", 1'b1, 1'b0, 32'h0000_1234, 256'd0, l032, 16'hFFFF,
                32'h0000_1220, l032};
    vecs[1] = '{"wr033", 1'b0, 1'b1, 32'hDEAD_BEEF,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                {4{64'hF00D_F00D_F00D_F00D}}, 16'hFFFF, 32'hDEAD_BEE0, l032};
    vecs[2] = '{"gap034", 1'b1, 1'b0, 32'h0000_0480, 256'd0, l034, 16'h0059,
                32'h0000_0480, l034};
    vecs[3] = '{"wb035", 1'b0, 1'b1, 32'h8000_003F,
                {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
                {4{64'hBAD0_BAD0_BAD0_BAD0}}, 16'hFFFF, 32'h8000_0020, l034};
    vecs[4] = '{"al035", 1'b1, 1'b0, 32'h0000_0040, 256'd0, l035r, 16'hFFFF,
                32'h0000_0040, l035r};
    vecs[5] = '{"both037", 1'b1, 1'b1, 32'h0000_0100,
                {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                {4{64'hDEAD_DEAD_DEAD_DEAD}}, 16'hFFFF, 32'h0000_0100, l035r};

    rst            = 1'b1;
    line_read_i    = 1'b0;
    line_write_i   = 1'b0;
    line_address_i = 32'd0;
    line_wdata_i   = 256'd0;
    burst_rdata_i  = 64'd0;
    resp_i         = 1'b0;
    last_line      = 256'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_read",  {255'd0, read_o},      256'd0);
    chk("rst_write", {255'd0, write_o},     256'd0);
    chk("rst_resp",  {255'd0, line_resp_o}, 256'd0);
    chk("rst_line",  line_rdata_o,          256'd0);
    chk("rst_addr",  {224'd0, address_o},   256'd0);
    chk("rst_wdata", {192'd0, burst_wdata_o}, 256'd0);
    @(posedge clk); #1;

    // Directed table, run back to back (covers writeback-then-allocate).
    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].nm, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
              vecs[i].beats, vecs[i].pat, 1'b0, vecs[i].exp_addr, vecs[i].exp_line);

    // Stray strobes in IDLE must not advance the beat counter.
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      burst_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      chk("stray_resp", {255'd0, line_resp_o}, 256'd0);
      chk("stray_line", line_rdata_o, last_line);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    run_txn(vecs[5].nm, vecs[5].rd, vecs[5].wr, vecs[5].addr, vecs[5].wd,
            vecs[5].beats, vecs[5].pat, 1'b0, vecs[5].exp_addr, vecs[5].exp_line);

    // Reset after three read beats aborts the burst.
    line_read_i    = 1'b1;
    line_address_i = 32'h0000_2040;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      resp_i        = 1'b1;
      burst_rdata_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    resp_i      = 1'b0;
    line_read_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_read",  {255'd0, read_o},      256'd0);
    chk("abort_write", {255'd0, write_o},     256'd0);
    chk("abort_resp",  {255'd0, line_resp_o}, 256'd0);
    chk("abort_line",  line_rdata_o,          256'd0);
    chk("abort_addr",  {224'd0, address_o},   256'd0);
    last_line = 256'd0;
    @(posedge clk); #1;
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_stray_resp", {255'd0, line_resp_o}, 256'd0);
      chk("abort_stray_read", {255'd0, read_o},      256'd0);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    run_txn("fresh036", 1'b1, 1'b0, 32'h0000_3000, 256'd0, l032, 16'hFFFF, 1'b0,
            32'h0000_3000, l032);

    // Randomized transactions with random gaps and mid-burst input churn.
    for (int i = 0; i < 24; i++) begin
      int           kind;
      bit           rd, wr;
      logic [31:0]  a;
      logic [255:0] wd, bt, expl;
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      a    = $urandom;
      wd   = rnd256();
      bt   = rnd256();
      expl = (rd && !wr) ? bt : last_line;
      run_txn("rand", rd, wr, a, wd, bt, 16'($urandom), 1'b1,
              {a[31:5], 5'd0}, expl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
